// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: producer latency classes and stall reasons.
package hazard_scoreboard_pkg;

  localparam logic [2:0] LAT_ALU  = 3'd0;
  localparam logic [2:0] LAT_LOAD = 3'd1;
  localparam logic [2:0] LAT_MUL  = 3'd3;
  localparam logic [2:0] LAT_DIV  = 3'd7;

  typedef enum logic [1:0] {
    SR_NONE  = 2'b00,
    SR_EX    = 2'b01,
    SR_EARLY = 2'b10
  } stall_reason_e;

endpackage

// File: rtl/hazard_scoreboard_reg_timer.sv
// Per-register countdown of cycles until a pending result becomes forwardable.
module hazard_reg_timer #(
  parameter int CNT_W    = 4,
  parameter int BR_EXTRA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             freeze,
  output logic             busy,
  output logic             ex_haz,
  output logic             early_haz
);

  logic [CNT_W-1:0] cnt;

  // A load wins over the decrement of the same entry; freeze holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy      = (cnt != '0);
  assign early_haz = (cnt != '0);
  assign ex_haz    = (cnt > CNT_W'(BR_EXTRA));

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-aware hazard unit: stalls ID until its source operands are forwardable.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LAT  = 7,
  parameter int LAT_W    = 3,
  parameter int BR_EXTRA = 1,
  parameter int CNT_W    = 4,
  parameter int SCNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic                id_rs1_used,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_rs2_used,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_reg_write,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                id_early_use,
  input  logic                flush,
  input  logic                ext_stall,
  output logic                stall,
  output logic [1:0]          stall_reason,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [SCNT_W-1:0]   stall_count
);

  logic [NUM_REGS-1:0] ex_haz_vec;
  logic [NUM_REGS-1:0] early_haz_vec;
  logic [CNT_W-1:0]    load_val;
  logic                issue;
  logic                haz1;
  logic                haz2;
  logic                hazard;
  stall_reason_e       reason;

  // Register 0 is hardwired and never tracked.
  assign busy_mask[0]     = 1'b0;
  assign ex_haz_vec[0]    = 1'b0;
  assign early_haz_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_reg_timer #(
      .CNT_W    (CNT_W),
      .BR_EXTRA (BR_EXTRA)
    ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (issue && (id_rd == REG_AW'(r))),
      .load_val  (load_val),
      .freeze    (ext_stall),
      .busy      (busy_mask[r]),
      .ex_haz    (ex_haz_vec[r]),
      .early_haz (early_haz_vec[r])
    );
  end

  always_comb begin
    haz1   = id_early_use ? early_haz_vec[id_rs1] : ex_haz_vec[id_rs1];
    haz2   = id_early_use ? early_haz_vec[id_rs2] : ex_haz_vec[id_rs2];
    hazard = (id_rs1_used && (id_rs1 != '0) && haz1) ||
             (id_rs2_used && (id_rs2 != '0) && haz2);
    stall  = id_valid && !flush && hazard;
    reason = SR_NONE;
    if (stall) begin
      reason = id_early_use ? SR_EARLY : SR_EX;
    end
  end

  assign stall_reason = reason;

  assign issue = id_valid && !stall && !flush && !ext_stall &&
                 id_reg_write && (id_rd != '0);

  always_comb begin
    if (int'(id_lat) > MAX_LAT) begin
      load_val = CNT_W'(MAX_LAT);
    end else begin
      load_val = CNT_W'(id_lat);
    end
    load_val = load_val + CNT_W'(BR_EXTRA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && !ext_stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: cycle table plus flush/reset/saturation sequences.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_rs1_used;
  logic [4:0]  id_rs2;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic [2:0]  id_lat;
  logic        id_early_use;
  logic        flush;
  logic        ext_stall;
  logic        stall;
  logic [1:0]  stall_reason;
  logic [31:0] busy_mask;
  logic [31:0] stall_count;
  logic        s_stall;
  logic [1:0]  s_reason;
  logic [31:0] s_busy;
  logic [2:0]  s_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
    .id_early_use(id_early_use), .flush(flush), .ext_stall(ext_stall),
    .stall(stall), .stall_reason(stall_reason),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  // Narrow statistics counter so saturation is reachable in a few cycles.
  hazard_scoreboard #(.SCNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
    .id_early_use(id_early_use), .flush(flush), .ext_stall(ext_stall),
    .stall(s_stall), .stall_reason(s_reason),
    .busy_mask(s_busy), .stall_count(s_count)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  lat;
    logic        early;
    logic        ext;
    logic        e_stall;
    logic [1:0]  e_reason;
    logic [31:0] e_busy;
    logic [31:0] e_count;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [1:0] used,
                              logic [4:0] rd, logic rw, logic [2:0] lat, logic early,
                              logic ext, logic es, logic [1:0] er, logic [31:0] eb,
                              logic [31:0] ec);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.used = used; t.rd = rd; t.rw = rw;
    t.lat = lat; t.early = early; t.ext = ext; t.e_stall = es; t.e_reason = er;
    t.e_busy = eb; t.e_count = ec;
    return t;
  endfunction

  function automatic logic [31:0] b(int n);
    return 32'd1 << n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [1:0] used,
                       logic [4:0] rd, logic rw, logic [2:0] lat, logic early,
                       logic fl, logic ext);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_used = used[1]; id_rs2_used = used[0];
    id_rd = rd; id_reg_write = rw; id_lat = lat; id_early_use = early;
    flush = fl; ext_stall = ext;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a producer then hold a dependent EX consumer until it is released.
  task automatic run_dep(logic [2:0] lat, logic [4:0] rd, output int n);
    n = 0;
    drive(1, 0, 0, 2'b11, rd, 1, lat, 0, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, rd, 0, 2'b11, 0, 0, LAT_ALU, 0, 0, 0);
      #2;
      if (!stall) break;
      n++;
      tick();
    end
    tick();
    drive(0, 0, 0, 2'b00, 0, 0, LAT_ALU, 0, 0, 0);
  endtask

  initial begin
    int n;
    drive(0, 0, 0, 2'b00, 0, 0, LAT_ALU, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_reason", {30'd0, stall_reason}, 32'd0);
    chk("reset_busy", busy_mask, 32'd0);
    chk("reset_count", stall_count, 32'd0);
    rst = 1'b0;

    tbl[0]  = mk(1, 0, 0, 2'b11,  5, 1, LAT_LOAD, 0, 0, 0, 2'b00, 0,      0);
    tbl[1]  = mk(1, 5, 0, 2'b11, 10, 1, LAT_ALU,  0, 0, 1, 2'b01, b(5),   0);
    tbl[2]  = mk(1, 5, 0, 2'b11, 10, 1, LAT_ALU,  0, 0, 0, 2'b00, b(5),   1);
    tbl[3]  = mk(1, 0, 0, 2'b11,  7, 1, LAT_ALU,  0, 0, 0, 2'b00, b(10),  1);
    tbl[4]  = mk(1, 7, 0, 2'b11,  0, 0, LAT_ALU,  1, 0, 1, 2'b10, b(7),   1);
    tbl[5]  = mk(1, 7, 0, 2'b11,  0, 0, LAT_ALU,  1, 0, 0, 2'b00, 0,      2);
    tbl[6]  = mk(1, 0, 0, 2'b11,  8, 1, LAT_LOAD, 0, 0, 0, 2'b00, 0,      2);
    tbl[7]  = mk(1, 8, 0, 2'b11,  0, 0, LAT_ALU,  1, 0, 1, 2'b10, b(8),   2);
    tbl[8]  = mk(1, 8, 0, 2'b11,  0, 0, LAT_ALU,  1, 0, 1, 2'b10, b(8),   3);
    tbl[9]  = mk(1, 8, 0, 2'b11,  0, 0, LAT_ALU,  1, 0, 0, 2'b00, 0,      4);
    tbl[10] = mk(1, 0, 0, 2'b11,  3, 1, LAT_MUL,  0, 0, 0, 2'b00, 0,      4);
    tbl[11] = mk(1, 3, 0, 2'b11, 11, 1, LAT_ALU,  0, 0, 1, 2'b01, b(3),   4);
    tbl[12] = mk(1, 3, 0, 2'b11, 11, 1, LAT_ALU,  0, 1, 1, 2'b01, b(3),   5);
    tbl[13] = mk(1, 3, 0, 2'b11, 11, 1, LAT_ALU,  0, 1, 1, 2'b01, b(3),   5);
    tbl[14] = mk(1, 3, 0, 2'b11, 11, 1, LAT_ALU,  0, 0, 1, 2'b01, b(3),   5);
    tbl[15] = mk(1, 3, 0, 2'b11, 11, 1, LAT_ALU,  0, 0, 1, 2'b01, b(3),   6);
    tbl[16] = mk(1, 3, 0, 2'b11, 11, 1, LAT_ALU,  0, 0, 0, 2'b00, b(3),   7);
    tbl[17] = mk(1, 0, 0, 2'b11,  0, 1, LAT_DIV,  0, 0, 0, 2'b00, b(11),  7);
    tbl[18] = mk(1, 0, 0, 2'b11,  0, 1, LAT_LOAD, 1, 0, 0, 2'b00, 0,      7);
    tbl[19] = mk(1, 0, 0, 2'b11,  4, 1, LAT_LOAD, 0, 0, 0, 2'b00, 0,      7);
    tbl[20] = mk(1, 4, 4, 2'b11,  4, 1, LAT_ALU,  0, 0, 1, 2'b01, b(4),   7);
    tbl[21] = mk(1, 4, 4, 2'b11,  4, 1, LAT_ALU,  0, 0, 0, 2'b00, b(4),   8);
    tbl[22] = mk(0, 4, 4, 2'b11,  4, 1, LAT_ALU,  1, 0, 0, 2'b00, b(4),   8);
    tbl[23] = mk(0, 0, 0, 2'b11,  0, 0, LAT_ALU,  0, 0, 0, 2'b00, 0,      8);
    tbl[24] = mk(1, 0, 0, 2'b11,  6, 1, LAT_DIV,  0, 0, 0, 2'b00, 0,      8);
    tbl[25] = mk(1, 6, 6, 2'b00,  0, 0, LAT_ALU,  0, 0, 0, 2'b00, b(6),   8);
    tbl[26] = mk(1, 6, 6, 2'b01,  0, 0, LAT_ALU,  0, 0, 1, 2'b01, b(6),   8);

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].used, tbl[i].rd, tbl[i].rw,
            tbl[i].lat, tbl[i].early, 0, tbl[i].ext);
      #2;
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d_reason", i), {30'd0, stall_reason}, {30'd0, tbl[i].e_reason});
      chk($sformatf("v%0d_busy", i), busy_mask, tbl[i].e_busy);
      chk($sformatf("v%0d_count", i), stall_count, tbl[i].e_count);
      tick();
    end

    // Flush of a dependent instruction: no stall, no issue, producer still drains.
    drive(1, 0, 0, 2'b11, 9, 1, LAT_LOAD, 0, 0, 0);
    tick();
    drive(1, 9, 0, 2'b11, 12, 1, LAT_ALU, 0, 1, 0);
    #2;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_busy9", {31'd0, busy_mask[9]}, 32'd1);
    tick();
    drive(0, 0, 0, 2'b00, 0, 0, LAT_ALU, 0, 0, 0);
    #2;
    chk("flush_busy9_c1", {31'd0, busy_mask[9]}, 32'd1);
    chk("flush_no_issue", {31'd0, busy_mask[12]}, 32'd0);
    tick();
    #2;
    chk("flush_busy9_c2", {31'd0, busy_mask[9]}, 32'd0);
    tick();

    // Reset while a load is pending, with a competing issue on the same edge.
    drive(1, 0, 0, 2'b11, 9, 1, LAT_LOAD, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b11, 9, 1, LAT_LOAD, 0, 0, 0);
    #2;
    chk("prerst_busy9", {31'd0, busy_mask[9]}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, LAT_ALU, 0, 0, 0);
    #2;
    chk("midrst_busy", busy_mask, 32'd0);
    chk("midrst_count", stall_count, 32'd0);
    chk("midrst_sat_count", {29'd0, s_count}, 32'd0);

    // Stall length equals producer latency; narrow counter saturates at 7.
    run_dep(3'd6, 5'd13, n);
    chk("dep6_cycles", n, 6);
    #2;
    chk("dep6_count", stall_count, 32'd6);
    chk("dep6_sat_count", {29'd0, s_count}, 32'd6);
    tick();
    run_dep(LAT_MUL, 5'd14, n);
    chk("dep3_cycles", n, 3);
    #2;
    chk("sat_wide_count", stall_count, 32'd9);
    chk("sat_narrow_count", {29'd0, s_count}, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
